// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared combinational ALU.
// Grants one requester at a time (round-robin by default), holds its operands
// on the ALU for one EXEC cycle, then presents the result until the owning
// requester takes it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req_op  [2*OPW-1:0]        packed opcodes {op1,op0}
//   req_a/req_b [2*DW-1:0]     packed operands {x1,x0}
//   rsp_valid [1:0]            one-hot response toward the owner
//   rsp_ready [1:0]            per-requester response consumed
//   rsp_data  [DW-1:0]         captured ALU result
//   alu_op/alu_a/alu_b         drive to the shared ALU
//   alu_result [DW-1:0]        combinational ALU result
//   busy                       a transaction is in flight
//
// Build option: define ARB_FIXED_PRIO_EN to make requester 0 always win when
// it is valid; the round-robin pointer is then not built.
module alu_arbiter #(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OPW-1:0]  req_op,
  input  logic [2*DW-1:0]   req_a,
  input  logic [2*DW-1:0]   req_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic [OPW-1:0]    alu_op,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_result,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic            owner;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [1:0]      grant;
  logic            accept;
  logic            gidx;

`ifndef ARB_FIXED_PRIO_EN
  // Index of the requester granted most recently; resets to 1 so 0 wins first.
  logic            last;
`endif

  // Grant selection among currently valid requesters.
  always_comb begin
    grant = 2'b00;
`ifdef ARB_FIXED_PRIO_EN
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
`else
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
`endif
  end

  // Ready must answer req_valid in the same cycle, so it is combinational;
  // gating with rst_n keeps it low while reset is held.
  assign req_ready = (rst_n && (state == IDLE)) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gidx      = grant[1];
  assign busy      = (state != IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      alu_op    <= '0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= gidx;
            alu_op <= gidx ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
            a_q    <= gidx ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
            b_q    <= gidx ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
`ifndef ARB_FIXED_PRIO_EN
            last   <= gidx;
`endif
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          alu_op    <= '0;
          rsp_valid <= {owner, ~owner};
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready closes the transaction.
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 5;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*OPW-1:0]  req_op;
  logic [2*DW-1:0]   req_a;
  logic [2*DW-1:0]   req_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [OPW-1:0]    alu_op;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [DW-1:0]     alu_result;
  logic              busy;

  int total;
  int bad;
  logic last_exp;
  // Scoreboard entry: {one-hot owner, expected data}
  logic [DW+1:0] sb [$];
  logic [DW+1:0] ent;

  alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .busy(busy)
  );

  // Reference ALU: add, sub, xor, otherwise and.
  function automatic logic [DW-1:0] alu_model(input logic [OPW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (op)
      5'b01101: return a + b;
      5'b01110: return a - b;
      5'b00110: return a ^ b;
      default:  return a & b;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    last_exp = 1'b1;
    sb.delete();
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_op = '1; req_a = '1; req_b = '1;
    tick();
    tick();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    total++; if (alu_op !== '0) begin bad++; $display("FAIL reset_alu_op: got %b want 0", alu_op); end
    total++; if (alu_a !== '0 || alu_b !== '0) begin bad++; $display("FAIL reset_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b1;
    last_exp = 1'b1;
    tick();
  endtask

  task automatic test_single;
    req_op = {5'd0, 5'b01101};
    req_a  = {32'd0, 32'd5};
    req_b  = {32'd0, 32'd7};
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
    sb.push_back({2'b01, 32'd12});
    tick();
    req_valid = 2'b00;
    #1;
    total++; if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin bad++; $display("FAIL single_exec_ctl: got busy=%b rdy=%b rv=%b want 1/00/00", busy, req_ready, rsp_valid); end
    total++; if (alu_op !== 5'b01101 || alu_a !== 32'd5 || alu_b !== 32'd7) begin bad++; $display("FAIL single_alu_drive: got %b %0d %0d want 01101 5 7", alu_op, alu_a, alu_b); end
    tick();
    ent = sb.pop_front();
    total++; if (rsp_valid !== ent[DW+1:DW] || rsp_data !== ent[DW-1:0]) begin bad++; $display("FAIL single_rsp: got %b/%0d want %b/%0d", rsp_valid, rsp_data, ent[DW+1:DW], ent[DW-1:0]); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    total++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || alu_op !== '0 || alu_a !== 32'd5) begin bad++; $display("FAIL single_done: got rv=%b busy=%b op=%b a=%0d want 00/0/0/5", rsp_valid, busy, alu_op, alu_a); end
    last_exp = 1'b0;
  endtask

  task automatic test_rr_pair;
    do_reset();
    req_op = {5'b00110, 5'b01110};
    req_a  = {32'hF0, 32'd10};
    req_b  = {32'hFF, 32'd3};
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rr_first_grant: got %b want 01", req_ready); end
    sb.push_back({2'b01, 32'd7});
    tick();
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rr_exec_ready: got %b want 00", req_ready); end
    tick();
    ent = sb.pop_front();
    total++; if (rsp_valid !== ent[DW+1:DW] || rsp_data !== ent[DW-1:0]) begin bad++; $display("FAIL rr_rsp0: got %b/%h want %b/%h", rsp_valid, rsp_data, ent[DW+1:DW], ent[DW-1:0]); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rr_second_grant: got %b want 10", req_ready); end
    sb.push_back({2'b10, 32'h0F});
    tick();
    req_valid = 2'b00;
    tick();
    total++; if (rsp_valid !== sb[0][DW+1:DW] || rsp_data !== sb[0][DW-1:0]) begin bad++; $display("FAIL rr_rsp1: got %b/%h want %b/%h", rsp_valid, rsp_data, sb[0][DW+1:DW], sb[0][DW-1:0]); end
    rsp_ready = 2'b01;
    tick();
    total++; if (rsp_valid !== 2'b10 || busy !== 1'b1) begin bad++; $display("FAIL rr_nonowner_ready: got rv=%b busy=%b want 10/1", rsp_valid, busy); end
    rsp_ready = 2'b10;
    tick();
    ent = sb.pop_front();
    rsp_ready = 2'b00;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rr_rsp1_done: got %b want 00", rsp_valid); end
    last_exp = 1'b1;
  endtask

  task automatic test_backpressure;
    req_op = {5'b01101, 5'b00110};
    req_a  = {32'd100, 32'd1};
    req_b  = {32'd23, 32'd1};
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_grant: got %b want 10", req_ready); end
    sb.push_back({2'b10, 32'd123});
    tick();
    req_valid = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rsp_valid !== sb[0][DW+1:DW] || rsp_data !== sb[0][DW-1:0] || busy !== 1'b1 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold%0d: got rv=%b d=%0d busy=%b rdy=%b want %b/%0d/1/00", i, rsp_valid, rsp_data, busy, req_ready, sb[0][DW+1:DW], sb[0][DW-1:0]);
      end
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    ent = sb.pop_front();
    rsp_ready = 2'b00;
    total++; if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin bad++; $display("FAIL bp_release: got rdy=%b rv=%b want 01/00", req_ready, rsp_valid); end
    req_valid = 2'b00;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_withdraw_ready: got %b want 00", req_ready); end
    tick();
    total++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin bad++; $display("FAIL bp_withdraw_idle: got busy=%b rv=%b want 0/00", busy, rsp_valid); end
  endtask

  task automatic test_reset_exec;
    req_op = {5'b01110, 5'b01101};
    req_a  = {32'd50, 32'd1};
    req_b  = {32'd8, 32'd2};
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rx_grant: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (alu_op !== '0 || alu_a !== '0 || alu_b !== '0 || rsp_data !== '0) begin bad++; $display("FAIL rx_zero_data: got op=%b a=%h b=%h d=%h want all 0", alu_op, alu_a, alu_b, rsp_data); end
    total++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin bad++; $display("FAIL rx_zero_ctl: got rv=%b busy=%b rdy=%b want 00/0/00", rsp_valid, busy, req_ready); end
    tick();
    rst_n = 1'b1;
    last_exp = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rx_grant_after: got %b want 01", req_ready); end
    sb.push_back({2'b01, 32'd3});
    tick();
    req_valid = 2'b00;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rx_no_stale: got %b want 00", rsp_valid); end
    tick();
    ent = sb.pop_front();
    total++; if (rsp_valid !== ent[DW+1:DW] || rsp_data !== ent[DW-1:0]) begin bad++; $display("FAIL rx_rsp: got %b/%0d want %b/%0d", rsp_valid, rsp_data, ent[DW+1:DW], ent[DW-1:0]); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    last_exp = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [OPW-1:0] ops [4];
    logic [OPW-1:0] o0, o1, op_g;
    logic [DW-1:0]  a0, a1, b0, b1;
    logic [1:0]     g;
    ops[0] = 5'b01101; ops[1] = 5'b01110; ops[2] = 5'b00110; ops[3] = 5'b00001;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      o0 = ops[$urandom_range(0, 3)];
      o1 = ops[$urandom_range(0, 3)];
      a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
      req_op = {o1, o0};
      req_a  = {a1, a0};
      req_b  = {b1, b0};
`ifdef ARB_FIXED_PRIO_EN
      g = 2'b01;
`else
      g = last_exp ? 2'b01 : 2'b10;
`endif
      #1;
      total++; if (req_ready !== g) begin bad++; $display("FAIL b2b_grant%0d: got %b want %b", k, req_ready, g); end
      op_g = g[1] ? o1 : o0;
      sb.push_back({g, g[1] ? alu_model(o1, a1, b1) : alu_model(o0, a0, b0)});
      last_exp = g[1];
      tick();
      total++; if (req_ready !== 2'b00 || alu_op !== op_g) begin bad++; $display("FAIL b2b_exec%0d: got rdy=%b op=%b want 00/%b", k, req_ready, alu_op, op_g); end
      tick();
      ent = sb.pop_front();
      total++; if (rsp_valid !== ent[DW+1:DW] || rsp_data !== ent[DW-1:0] || req_ready !== 2'b00) begin bad++; $display("FAIL b2b_rsp%0d: got %b/%h rdy=%b want %b/%h/00", k, rsp_valid, rsp_data, req_ready, ent[DW+1:DW], ent[DW-1:0]); end
      tick();
    end
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL b2b_req1_alone: got %b want 10", req_ready); end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    last_exp = 1'b1;
    test_reset();
    test_single();
    test_rr_pair();
    test_backpressure();
    test_reset_exec();
    test_back_to_back();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drained: got %0d entries want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
